wb_ram_burst: RTL and testbench
===============================

# wb_ram_burst

Parametrised Wishbone slave RAM, successor to the fixed 8-bit single-cycle RAM slave. It adds:
- configurable data width, address width and depth;
- byte-lane write enables;
- a registered acknowledge;
- incrementing-burst support with an internal address counter;
- an error response for out-of-range addresses.

It sits on the MIDI router's internal Wishbone bus as packet/scratch storage for the message-handling master.

## Interface
- DW, 8, data width in bits; multiple of 8
- AW, 8, address width in bits (word addresses)
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2^AW
- wb_clk_i  in  1  system clock, all state changes on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle in progress
- wb_stb_i  in  1  transfer strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_addr_i  in  AW  word address
- wb_sel_i  in  DW/8  byte-lane write enables
- wb_cti_i  in  3  cycle type: 3'b000 classic, 3'b010 incrementing burst, 3'b111 end of burst
- wb_dat_i  in  DW  write data
- wb_dat_o  out  DW  read data, registered
- wb_ack_o  out  1  transfer acknowledge, registered
- wb_err_o  out  1  error acknowledge, registered

## Operation
- Storage: DEPTH × DW register array. Contents are not reset.
- Request: `req = wb_cyc_i & wb_stb_i`.
- Beat completion: a beat completes on the rising edge where `req` is high and `wb_ack_o` is high.
- Writes: commit at beat completion, writing lane `i` only when `wb_sel_i[i]` is 1. Reads return the full word; `wb_sel_i` is ignored.
- Address pointer `ptr` (AW bits) is loaded from `wb_addr_i` on the first beat. In BURST, `ptr` is used for both reads and writes; `wb_addr_i` is ignored after the first beat.
- States and transitions:
  - IDLE:
    - `req` with `wb_addr_i ≥ DEPTH`: go to ERR.
    - Otherwise, on `req`: `ptr <= wb_addr_i`, and for reads `wb_dat_o <= mem[wb_addr_i]`. Go to SINGLE if `wb_cti_i ≠ 3'b010`, else BURST.
  - SINGLE: `wb_ack_o` = 1 for exactly one cycle, then IDLE. A write commits at `ptr` on that edge if `req` is still high.
  - BURST: `wb_ack_o` is held high.
    - On each completing edge: commit the write at `ptr`; `ptr <= (ptr+1 == DEPTH) ? 0 : ptr+1`; for reads, `wb_dat_o <= mem[next ptr]`.
    - Completing edge with `wb_cti_i == 3'b111`: go to IDLE.
    - `wb_cyc_i` low at any edge: abort to IDLE, no commit.
    - `wb_stb_i` low with `wb_cyc_i` high is illegal in BURST. The slave treats it as an abort.
  - ERR: `wb_err_o` = 1 for one cycle, no memory access, then IDLE.
- `wb_ack_o` and `wb_err_o` are never high together.
- Read data is the pre-write value. A same-edge read/write collision is impossible because `wb_we_i` is fixed for the whole cycle.
- Burst pointer wrap is silent: no error is raised on wrap, even when DEPTH < 2^AW.

## Timing
- Reset (`wb_rst_i` = 0): immediately and asynchronously forces `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0, `ptr` = 0, state IDLE.
  - No write commits on an edge while reset is asserted.
  - Reset mid-burst discards the burst.
- Classic cycle:
  - `req` sampled at edge N; `wb_ack_o`/`wb_dat_o` valid after edge N, during cycle N+1.
  - `wb_ack_o` low after edge N+1, so each classic transfer takes 2 cycles and a back-to-back request is accepted at edge N+2.
- Burst:
  - First `wb_ack_o` as for a classic cycle, then one beat per clock with no wait states.
  - A burst of L beats occupies L+1 cycles from the first `req` edge.
- Error: `wb_err_o` high during cycle N+1 only.
- Master drops `wb_cyc_i` while `wb_ack_o` is high: `wb_ack_o` stays high for the remainder of that cycle and is low after the next edge. Nothing commits.

## Test plan
- Classic write then read (DW=8): write 0xA5 to 0x10, then read 0x10. Expect `wb_ack_o` one cycle after each `req`, 2 cycles per transfer, and read data 0xA5.
- Byte lanes (DW=16): write 0x1234 with sel=2'b11, then 0xABCD with sel=2'b01, to 0x05. Expect read data 0x12CD.
- Burst write with wrap (DEPTH=256): 4 beats starting at 0xFE, data 1, 2, 3, 4, cti 010, 010, 010, 111. Expect words 0xFE, 0xFF, 0x00, 0x01 to hold 1–4, `wb_ack_o` continuous for 4 cycles, then IDLE.
- Burst read: 4 beats starting at 0xFE. Expect `wb_dat_o` 1, 2, 3, 4 on consecutive ack cycles, with the first ack 1 cycle after `req`.
- Out of range (DEPTH=200): write 0x77 to 0xC8. Expect `wb_err_o` pulse for 1 cycle, no `wb_ack_o`, and word 0x00 unchanged.
- Reset/abort:
  - Assert `wb_rst_i` low during beat 2 of a write burst. Expect outputs to go to 0 within the same cycle, only beat 1 committed, and a classic read afterwards to work.
  - Drop `wb_cyc_i` mid-burst. Expect IDLE after the next edge, with no further writes.

Source files
------------

// File: rtl/wb_ram_burst_if.sv
// Wishbone bus bundle for the burst RAM slave: master drives the request side,
// slave returns registered data and ack/err.
interface wb_ram_burst_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_we_i;
    logic [AW-1:0]   wb_addr_i;
    logic [DW/8-1:0] wb_sel_i;
    logic [2:0]      wb_cti_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_cti_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_cti_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_ram_burst.sv
// Parametrised Wishbone slave RAM with byte lanes, registered ack/err,
// incrementing bursts through an internal pointer and out-of-range error.
module wb_ram_burst #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_ram_burst_if.slave  bus
);
    localparam int LANES = DW / 8;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] nxt;
    logic [AW:0]   inc;
    logic          req;
    logic          wr_en;
    logic [DW-1:0] mem [DEPTH];

    assign req = bus.wb_cyc_i & bus.wb_stb_i;
    assign inc = {1'b0, ptr} + (AW+1)'(1);
    // Wrap silently at DEPTH, which need not be a power of two.
    assign nxt = (inc == DEPTH_W) ? '0 : inc[AW-1:0];
    // ack is only ever high in SINGLE/BURST, so req & ack marks a completing beat.
    assign wr_en = wb_rst_i & req & bus.wb_ack_o & bus.wb_we_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state        <= IDLE;
            ptr          <= '0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            bus.wb_dat_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if ({1'b0, bus.wb_addr_i} >= DEPTH_W) begin
                            bus.wb_err_o <= 1'b1;
                            state        <= ERR;
                        end else begin
                            ptr          <= bus.wb_addr_i;
                            bus.wb_ack_o <= 1'b1;
                            if (!bus.wb_we_i) bus.wb_dat_o <= mem[bus.wb_addr_i];
                            state <= (bus.wb_cti_i == CTI_INC) ? BURST : SINGLE;
                        end
                    end
                end
                SINGLE: begin
                    bus.wb_ack_o <= 1'b0;
                    state        <= IDLE;
                end
                BURST: begin
                    // Dropped cyc or stb both end the burst without a commit.
                    if (!req) begin
                        bus.wb_ack_o <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        ptr <= nxt;
                        if (!bus.wb_we_i) bus.wb_dat_o <= mem[nxt];
                        if (bus.wb_cti_i == CTI_EOB) begin
                            bus.wb_ack_o <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                ERR: begin
                    bus.wb_err_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wb_sel_i[l]) mem[ptr][l*8 +: 8] <= bus.wb_dat_i[l*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed bench: bus A is DW=16/DEPTH=256 (lanes, bursts, reset, abort),
// bus B is DW=8/DEPTH=200 (classic transfers, out-of-range error).
module tb_wb_ram_burst;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] rd16;
    logic [7:0]  rd8;

    always #5 clk = ~clk;

    wb_ram_burst_if #(.DW(16), .AW(8)) bus_a ();
    wb_ram_burst_if #(.DW(8),  .AW(8)) bus_b ();

    wb_ram_burst #(.DW(16), .AW(8), .DEPTH(256)) u_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus_a.slave)
    );

    wb_ram_burst #(.DW(8), .AW(8), .DEPTH(200)) u_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic rel_a();
        bus_a.wb_cyc_i = 0; bus_a.wb_stb_i = 0; bus_a.wb_we_i = 0;
        bus_a.wb_addr_i = '0; bus_a.wb_sel_i = '0; bus_a.wb_cti_i = '0; bus_a.wb_dat_i = '0;
    endtask

    task automatic rel_b();
        bus_b.wb_cyc_i = 0; bus_b.wb_stb_i = 0; bus_b.wb_we_i = 0;
        bus_b.wb_addr_i = '0; bus_b.wb_sel_i = '0; bus_b.wb_cti_i = '0; bus_b.wb_dat_i = '0;
    endtask

    task automatic xfer_a(input string tag, input logic we, input logic [7:0] addr,
                          input logic [15:0] d, input logic [1:0] sel, output logic [15:0] rd);
        @(negedge clk);
        bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = we;
        bus_a.wb_addr_i = addr; bus_a.wb_dat_i = d; bus_a.wb_sel_i = sel; bus_a.wb_cti_i = 3'b000;
        @(negedge clk);
        chk({tag, ".ack"}, 32'(bus_a.wb_ack_o), 1);
        rd = bus_a.wb_dat_o;
        @(negedge clk);
        chk({tag, ".ack_lo"}, 32'(bus_a.wb_ack_o), 0);
        rel_a();
    endtask

    task automatic xfer_b(input string tag, input logic we, input logic [7:0] addr,
                          input logic [7:0] d, output logic [7:0] rd);
        @(negedge clk);
        bus_b.wb_cyc_i = 1; bus_b.wb_stb_i = 1; bus_b.wb_we_i = we;
        bus_b.wb_addr_i = addr; bus_b.wb_dat_i = d; bus_b.wb_sel_i = 1'b1; bus_b.wb_cti_i = 3'b000;
        @(negedge clk);
        chk({tag, ".ack"}, 32'(bus_b.wb_ack_o), 1);
        rd = bus_b.wb_dat_o;
        @(negedge clk);
        chk({tag, ".ack_lo"}, 32'(bus_b.wb_ack_o), 0);
        rel_b();
    endtask

    // 4-beat burst; addr is scrambled after the first beat to prove it is ignored.
    task automatic burst_a(input string tag, input logic we, input logic [7:0] addr,
                           input logic [15:0] d0, d1, d2, d3);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        @(negedge clk);
        bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = we;
        bus_a.wb_addr_i = addr; bus_a.wb_dat_i = d[0]; bus_a.wb_sel_i = 2'b11; bus_a.wb_cti_i = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("%s.ack%0d", tag, i), 32'(bus_a.wb_ack_o), 1);
            if (!we) chk($sformatf("%s.dat%0d", tag, i), 32'(bus_a.wb_dat_o), 32'(d[i]));
            bus_a.wb_addr_i = 8'h33;
            bus_a.wb_dat_i  = d[i];
            bus_a.wb_cti_i  = (i == 3) ? 3'b111 : 3'b010;
        end
        @(negedge clk);
        chk({tag, ".ack_end"}, 32'(bus_a.wb_ack_o), 0);
        rel_a();
    endtask

    initial begin
        rel_a();
        rel_b();
        #12;
        chk("rst.a_ack", 32'(bus_a.wb_ack_o), 0);
        chk("rst.a_err", 32'(bus_a.wb_err_o), 0);
        chk("rst.a_dat", 32'(bus_a.wb_dat_o), 0);
        chk("rst.b_ack", 32'(bus_b.wb_ack_o), 0);
        chk("rst.b_dat", 32'(bus_b.wb_dat_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Classic write then read, DW=8
        xfer_b("cls_wr", 1'b1, 8'h10, 8'hA5, rd8);
        xfer_b("cls_rd", 1'b0, 8'h10, 8'h00, rd8);
        chk("cls_rd.dat", 32'(rd8), 32'h A5);

        // Byte lanes, DW=16
        xfer_a("lane_wr1", 1'b1, 8'h05, 16'h1234, 2'b11, rd16);
        xfer_a("lane_wr2", 1'b1, 8'h05, 16'hABCD, 2'b01, rd16);
        xfer_a("lane_rd", 1'b0, 8'h05, 16'h0000, 2'b00, rd16);
        chk("lane_rd.dat", 32'(rd16), 32'h12CD);

        // Burst write wrapping 0xFE..0x01, then read back as burst and singly
        burst_a("bwr", 1'b1, 8'hFE, 16'd1, 16'd2, 16'd3, 16'd4);
        burst_a("brd", 1'b0, 8'hFE, 16'd1, 16'd2, 16'd3, 16'd4);
        xfer_a("wrap_rd0", 1'b0, 8'h00, 16'h0, 2'b00, rd16);
        chk("wrap_rd0.dat", 32'(rd16), 3);
        xfer_a("wrap_rd1", 1'b0, 8'h01, 16'h0, 2'b00, rd16);
        chk("wrap_rd1.dat", 32'(rd16), 4);

        // Out of range on DEPTH=200; last valid word still usable
        xfer_b("oor_pre", 1'b1, 8'h00, 8'h3C, rd8);
        xfer_b("top_wr", 1'b1, 8'hC7, 8'h5A, rd8);
        @(negedge clk);
        bus_b.wb_cyc_i = 1; bus_b.wb_stb_i = 1; bus_b.wb_we_i = 1;
        bus_b.wb_addr_i = 8'hC8; bus_b.wb_dat_i = 8'h77; bus_b.wb_sel_i = 1'b1;
        @(negedge clk);
        chk("oor.err", 32'(bus_b.wb_err_o), 1);
        chk("oor.ack", 32'(bus_b.wb_ack_o), 0);
        @(negedge clk);
        chk("oor.err_lo", 32'(bus_b.wb_err_o), 0);
        chk("oor.ack_lo", 32'(bus_b.wb_ack_o), 0);
        rel_b();
        xfer_b("oor_rd0", 1'b0, 8'h00, 8'h00, rd8);
        chk("oor_rd0.dat", 32'(rd8), 32'h3C);
        xfer_b("top_rd", 1'b0, 8'hC7, 8'h00, rd8);
        chk("top_rd.dat", 32'(rd8), 32'h5A);

        // Reset during beat 2 of a write burst
        xfer_a("rst_pre", 1'b1, 8'h21, 16'hEEEE, 2'b11, rd16);
        xfer_a("rst_prerd", 1'b0, 8'h21, 16'h0, 2'b00, rd16);
        chk("rst_prerd.dat", 32'(rd16), 32'hEEEE);
        @(negedge clk);
        bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = 1;
        bus_a.wb_addr_i = 8'h20; bus_a.wb_dat_i = 16'h0011; bus_a.wb_sel_i = 2'b11; bus_a.wb_cti_i = 3'b010;
        @(negedge clk);
        chk("rstb.ack0", 32'(bus_a.wb_ack_o), 1);
        @(negedge clk);
        bus_a.wb_dat_i = 16'h0022;
        chk("rstb.ack1", 32'(bus_a.wb_ack_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstb.ack_async", 32'(bus_a.wb_ack_o), 0);
        chk("rstb.dat_async", 32'(bus_a.wb_dat_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rel_a();
        chk("rstb.ack_after", 32'(bus_a.wb_ack_o), 0);
        xfer_a("rstb_rd20", 1'b0, 8'h20, 16'h0, 2'b00, rd16);
        chk("rstb_rd20.dat", 32'(rd16), 32'h0011);
        xfer_a("rstb_rd21", 1'b0, 8'h21, 16'h0, 2'b00, rd16);
        chk("rstb_rd21.dat", 32'(rd16), 32'hEEEE);

        // Master drops cyc mid-burst
        xfer_a("abt_pre1", 1'b1, 8'h41, 16'h5555, 2'b11, rd16);
        xfer_a("abt_pre2", 1'b1, 8'h42, 16'h5555, 2'b11, rd16);
        @(negedge clk);
        bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = 1;
        bus_a.wb_addr_i = 8'h40; bus_a.wb_dat_i = 16'h00AA; bus_a.wb_sel_i = 2'b11; bus_a.wb_cti_i = 3'b010;
        @(negedge clk);
        chk("abt.ack0", 32'(bus_a.wb_ack_o), 1);
        @(negedge clk);
        chk("abt.ack1", 32'(bus_a.wb_ack_o), 1);
        bus_a.wb_cyc_i = 0;
        bus_a.wb_dat_i = 16'h00BB;
        #1;
        chk("abt.ack_hold", 32'(bus_a.wb_ack_o), 1);
        @(negedge clk);
        chk("abt.ack_lo", 32'(bus_a.wb_ack_o), 0);
        @(negedge clk);
        chk("abt.idle", 32'(bus_a.wb_ack_o), 0);
        rel_a();
        xfer_a("abt_rd40", 1'b0, 8'h40, 16'h0, 2'b00, rd16);
        chk("abt_rd40.dat", 32'(rd16), 32'h00AA);
        xfer_a("abt_rd41", 1'b0, 8'h41, 16'h0, 2'b00, rd16);
        chk("abt_rd41.dat", 32'(rd16), 32'h5555);
        xfer_a("abt_rd42", 1'b0, 8'h42, 16'h0, 2'b00, rd16);
        chk("abt_rd42.dat", 32'(rd16), 32'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
